// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch engine: PC width, reset/bubble defaults, fetch FSM states.
package mips_pkg;

  localparam int unsigned PC_W         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_ISSUE,
    FETCH_WAIT,
    FETCH_READY
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_pc_sel.sv
// Next-PC selection: PC+4, branch target or jump target (jump wins), targets forced word aligned.
module fetch_pc_sel
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            stall_f,
  input  logic            pc_src_d,
  input  logic [PC_W-1:0] pc_branch_d,
  input  logic            jump_d,
  input  logic [PC_W-1:0] pc_jump_d,
  output logic            redirect,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    redirect    = ~stall_f & (pc_src_d | jump_d);
    target      = jump_d ? pc_jump_d : pc_branch_d;
    target[1:0] = '0;
    pc_plus4    = pc + PC_W'(4);
    next_pc     = redirect ? target : pc_plus4;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, handshakes with variable-latency instruction memory,
// presents instructions (or NOP bubbles) to IF/ID and drops responses made stale by redirects.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic        jump_d,
  input  logic [31:0] pc_jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus4_f,
  output logic        instr_valid_f,
  output logic        fetch_busy
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            kill;
  logic [31:0]     instr_buf;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] next_pc;

  fetch_pc_sel u_pc_sel (
    .pc          (pc),
    .stall_f     (stall_f),
    .pc_src_d    (pc_src_d),
    .pc_branch_d (pc_branch_d),
    .jump_d      (jump_d),
    .pc_jump_d   (pc_jump_d),
    .redirect    (redirect),
    .target      (target),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_ISSUE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      instr_buf <= NOP_INSTR;
    end else begin
      case (state)
        FETCH_ISSUE: begin
          state <= FETCH_WAIT;
          if (redirect) begin
            pc   <= target;
            kill <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_ack) begin
            kill <= 1'b0;
            if (!kill && !redirect) begin
              instr_buf <= imem_rdata;
              state     <= FETCH_READY;
            end else begin
              // Stale word dropped; a redirect arriving with the ack still retargets the refetch.
              state <= FETCH_ISSUE;
              if (redirect) pc <= target;
            end
          end else if (redirect) begin
            pc   <= target;
            kill <= 1'b1;
          end
        end
        FETCH_READY: begin
          if (!stall_f) begin
            pc    <= next_pc;
            state <= FETCH_WAIT;
          end
        end
        default: state <= FETCH_ISSUE;
      endcase
    end
  end

  // Request is gated by rst_n so nothing is issued while reset is held.
  always_comb begin
    imem_req      = rst_n & ((state == FETCH_ISSUE) | ((state == FETCH_READY) & ~stall_f));
    imem_addr     = (state == FETCH_READY) ? next_pc : pc;
    instr_valid_f = (state == FETCH_READY);
    instr_f       = instr_valid_f ? instr_buf : NOP_INSTR;
    pc_plus4_f    = instr_valid_f ? pc_plus4 : '0;
    fetch_busy    = (state == FETCH_WAIT);
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random stimulus against a
// transaction-level model of the fetch engine and a randomly-latent instruction memory.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        pc_src_d;
  logic [31:0] pc_branch_d;
  logic        jump_d;
  logic [31:0] pc_jump_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_plus4_f;
  logic        instr_valid_f;
  logic        fetch_busy;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .pc_src_d      (pc_src_d),
    .pc_branch_d   (pc_branch_d),
    .jump_d        (jump_d),
    .pc_jump_d     (pc_jump_d),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_f       (instr_f),
    .pc_plus4_f    (pc_plus4_f),
    .instr_valid_f (instr_valid_f),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: architectural pc, whether an instruction is held for IF/ID, whether a request
  // is outstanding and whether that outstanding word has been made stale by a redirect.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_pend;
  logic        m_stale;

  // Memory
  logic        mem_busy;
  int          mem_due;
  logic [31:0] mem_word;
  int          lat_cfg     = 1;
  logic        rand_lat    = 1'b0;
  logic        bad_word    = 1'b0;
  logic        allow_stray = 1'b0;

  // Observation
  logic [31:0] q_addr[$];
  logic [31:0] q_pc4[$];
  logic [31:0] last_req_addr;
  logic [31:0] last_pc4;
  int          req_count = 0;
  logic        seen_bad  = 1'b0;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_stale = 1'b0;
  endtask

  task automatic cycle();
    logic        rd;
    logic [31:0] tg;
    logic        e_req, e_valid, e_busy;
    logic [31:0] e_addr, e_instr, e_pc4;
    @(negedge clk);
    rd = ~stall_f & (pc_src_d | jump_d);
    tg = (jump_d ? pc_jump_d : pc_branch_d) & ~32'h3;
    e_req = 1'b0; e_addr = '0; e_valid = 1'b0; e_instr = NOP_INSTR; e_pc4 = '0; e_busy = 1'b0;
    if (rst_n) begin
      if (m_valid) begin
        e_valid = 1'b1;
        e_instr = m_instr;
        e_pc4   = m_pc + 32'd4;
        e_req   = ~stall_f;
        e_addr  = rd ? tg : m_pc + 32'd4;
      end else if (!m_pend) begin
        e_req  = 1'b1;
        e_addr = m_pc;
      end else begin
        e_busy = 1'b1;
      end
    end
    check("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) check("imem_addr", imem_addr, e_addr);
    check("instr_valid_f", 32'(instr_valid_f), 32'(e_valid));
    check("instr_f", instr_f, e_instr);
    check("pc_plus4_f", pc_plus4_f, e_pc4);
    check("fetch_busy", 32'(fetch_busy), 32'(e_busy));
    if (imem_ack && !allow_stray) check("ack_in_wait", 32'(fetch_busy), 32'd1);

    if (imem_req) begin
      q_addr.push_back(imem_addr);
      last_req_addr = imem_addr;
      req_count++;
    end
    if (instr_valid_f) begin
      q_pc4.push_back(pc_plus4_f);
      last_pc4 = pc_plus4_f;
    end
    if (instr_f == BAD_WORD) seen_bad = 1'b1;

    if (e_req) begin
      mem_busy = 1'b1;
      mem_due  = rand_lat ? int'($urandom_range(1, 4)) : lat_cfg;
      mem_word = bad_word ? BAD_WORD : $urandom;
    end

    if (!rst_n) begin
      model_reset();
    end else if (m_valid) begin
      if (!stall_f) begin
        m_valid = 1'b0;
        m_pend  = 1'b1;
        m_stale = 1'b0;
        m_pc    = e_addr;
      end
    end else if (!m_pend) begin
      m_pend  = 1'b1;
      m_stale = rd;
      if (rd) m_pc = tg;
    end else if (imem_ack) begin
      m_pend = 1'b0;
      if (m_stale || rd) begin
        m_stale = 1'b0;
        if (rd) m_pc = tg;
      end else begin
        m_valid = 1'b1;
        m_instr = imem_rdata;
      end
    end else if (rd) begin
      m_stale = 1'b1;
      m_pc    = tg;
    end

    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (mem_busy) begin
      mem_due--;
      if (mem_due == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word;
        mem_busy   = 1'b0;
      end
    end
  endtask

  task automatic run_until_ready(input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      cycle();
      n++;
    end
    check("ready_timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic wait_req(input int budget);
    int n  = 0;
    int rq = req_count;
    while (req_count == rq && n < budget) begin
      cycle();
      n++;
    end
    check("req_timeout", 32'(req_count != rq), 32'd1);
  endtask

  initial begin
    logic [31:0] held_pc;
    int rc;
    int n;
    rst_n = 1'b0; stall_f = 1'b0; pc_src_d = 1'b0; jump_d = 1'b0;
    pc_branch_d = '0; pc_jump_d = '0; imem_ack = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_due = 0; mem_word = '0;
    last_req_addr = '0; last_pc4 = '0;
    model_reset();

    // Reset state, then straight-line fetch with 1-cycle memory
    cycle();
    cycle();
    rst_n = 1'b1;
    q_addr.delete();
    q_pc4.delete();
    repeat (8) cycle();
    check("seq_nreq", 32'(q_addr.size() >= 3), 32'd1);
    check("seq_nvalid", 32'(q_pc4.size() >= 3), 32'd1);
    check("seq_addr0", q_addr[0], 32'h0);
    check("seq_addr1", q_addr[1], 32'h4);
    check("seq_addr2", q_addr[2], 32'h8);
    check("seq_pc4_0", q_pc4[0], 32'h4);
    check("seq_pc4_1", q_pc4[1], 32'h8);
    check("seq_pc4_2", q_pc4[2], 32'hC);

    // Stall for 3 cycles in READY
    run_until_ready(10);
    held_pc = m_pc;
    rc = req_count;
    stall_f = 1'b1;
    repeat (3) cycle();
    check("stall_noreq", 32'(req_count - rc), 32'd0);
    stall_f = 1'b0;
    cycle();
    check("stall_next", last_req_addr, held_pc + 32'd4);

    // Branch redirect in READY at pc=0x10
    n = 0;
    while (!(m_valid && m_pc == 32'h10) && n < 20) begin
      cycle();
      n++;
    end
    check("br_reach", m_pc, 32'h10);
    pc_src_d = 1'b1; pc_branch_d = 32'h40;
    cycle();
    pc_src_d = 1'b0;
    check("br_addr", last_req_addr, 32'h40);
    run_until_ready(10);
    cycle();
    check("br_pc4", last_pc4, 32'h44);

    // Redirect in WAIT; stale 0xDEADBEEF arrives 2 cycles later
    lat_cfg = 3; bad_word = 1'b1;
    wait_req(10);
    pc_src_d = 1'b1; pc_branch_d = 32'h80;
    cycle();
    pc_src_d = 1'b0; bad_word = 1'b0; lat_cfg = 1;
    wait_req(10);
    check("wait_redir_addr", last_req_addr, 32'h80);
    run_until_ready(10);
    cycle();
    check("no_stale_word", 32'(seen_bad), 32'd0);

    // Jump beats branch; unaligned jump target is aligned
    run_until_ready(10);
    pc_src_d = 1'b1; pc_branch_d = 32'h100; jump_d = 1'b1; pc_jump_d = 32'h200;
    cycle();
    pc_src_d = 1'b0; jump_d = 1'b0;
    check("jump_prio", last_req_addr, 32'h200);
    run_until_ready(10);
    jump_d = 1'b1; pc_jump_d = 32'h203;
    cycle();
    jump_d = 1'b0;
    check("jump_align", last_req_addr, 32'h200);

    // Reset asserted mid-WAIT, stray ack arrives after release
    lat_cfg = 3;
    wait_req(10);
    allow_stray = 1'b1;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    check("rst_stray_ack", 32'(imem_ack), 32'd1);
    rc = req_count;
    cycle();
    check("rst_refetch_n", 32'(req_count - rc), 32'd1);
    check("rst_refetch_addr", last_req_addr, RESET_PC);
    allow_stray = 1'b0;
    lat_cfg = 1;

    // Random traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      stall_f     = ($urandom_range(0, 3) == 0);
      pc_src_d    = ($urandom_range(0, 6) == 0);
      jump_d      = ($urandom_range(0, 8) == 0);
      pc_branch_d = $urandom;
      pc_jump_d   = $urandom;
      cycle();
    end
    stall_f = 1'b0; pc_src_d = 1'b0; jump_d = 1'b0;
    repeat (6) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
